bcd_count_ctrl: RTL and testbench

Sequencing controller for a cascade of NDIG single-digit BCD up/down counters; the counters have `en`/`dir`/clear inputs and a 4-bit `BCD` output. The block owns the run/pause/done state machine and a tick prescaler, and generates per-digit enables with decimal carry/borrow rippling. It also detects the terminal count (target reached counting up, zero reached counting down) and recovers from illegal digit codes. It sits between front-panel controls (start/stop/clear, mode, target) and the digit counter bank.

---
 rtl/bcd_count_ctrl.sv | 159 +++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run/pause/done sequencer for a cascade of NDIG BCD up/down digit counters.
// Owns the tick prescaler and generates per-digit enables with decimal carry/borrow ripple.
// It also detects the terminal count and recovers from illegal digit codes.
//
// Ports
//   clk      rising-edge system clock
//   reset    asynchronous active-low reset
//   start    pulse: begin (IDLE/DONE) or resume (PAUSE) counting
//   stop     pulse: toggle RUN <-> PAUSE
//   clear    pulse: abort to IDLE, clear counters and err
//   mode     direction request (0 = up, 1 = down), latched on an accepted start
//   target   BCD terminal value for up mode, digit 0 in [3:0]
//   digits   current counter outputs, digit 0 in [3:0]
//   dig_en   per-digit count enable
//   dig_dir  direction to counters (1 = up, 0 = down)
//   dig_clr  synchronous clear to counters
//   busy     high in RUN or PAUSE
//   done     one-cycle pulse on entry to DONE
//   err      sticky illegal-digit flag
module bcd_count_ctrl #(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned TICK_DIV = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              mode,
    input  logic [4*NDIG-1:0] target,
    input  logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   dig_en,
    output logic              dig_dir,
    output logic              dig_clr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned    CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic            illegal;
    logic            active;
    logic            bad;
    logic            tick;
    logic            term;
    logic            chain;
    logic [NDIG-1:0] roll;  // digit sits at its carry (9, up) or borrow (0, down) value

    always_comb begin
        illegal = 1'b0;
        roll    = '0;
        for (int i = 0; i < NDIG; i++) begin
            illegal = illegal | (digits[4*i +: 4] > 4'd9);
            roll[i] = dir_q ? (digits[4*i +: 4] == 4'd9) : (digits[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        active = (state_q == StRun) || (state_q == StPause);
        bad    = illegal && active;
        tick   = (state_q == StRun) && (cnt_q == CntMax);
        term   = dir_q ? (digits == target) : (digits == '0);
    end

    // Enables: a tick reaches digit i only if every lower digit is rolling over.
    always_comb begin
        dig_en = '0;
        chain  = 1'b0;
        if ((state_q == StRun) && !clear && !bad && !term) begin
            chain = tick;
            for (int i = 0; i < NDIG; i++) begin
                dig_en[i] = chain;
                chain     = chain & roll[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        err_d   = err_q;

        if (state_q == StRun) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end

        if (clear) begin
            state_d = StIdle;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (bad) begin
            state_d = StIdle;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRun;
                        dir_d   = ~mode;
                        cnt_d   = '0;
                    end
                end
                StRun: begin
                    // Terminal count outranks a stop issued in the same cycle.
                    if (term) begin
                        state_d = StDone;
                    end else if (stop) begin
                        state_d = StPause;
                    end
                end
                StPause: begin
                    if (stop || start) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        done_d = (state_q == StRun) && (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        dig_dir = dir_q;
        dig_clr = clear | bad;
        busy    = active;
        done    = done_q;
        err     = err_q;
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Testbench for bcd_count_ctrl: behavioural digit-counter bank as plant, arithmetic reference
// model producing one expected output set per cycle into a queue, monitor comparing on negedge.
module tb_bcd_count_ctrl;

    localparam int unsigned NDIG     = 2;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned W        = 4 * NDIG;

    logic            clk    = 1'b0;
    logic            reset  = 1'b0;
    logic            start  = 1'b0;
    logic            stop   = 1'b0;
    logic            clear  = 1'b0;
    logic            mode   = 1'b0;
    logic [W-1:0]    target = '0;
    logic [W-1:0]    digits;
    logic [NDIG-1:0] dig_en;
    logic            dig_dir, dig_clr, busy, done, err;

    always #5 clk = ~clk;

    bcd_count_ctrl #(.NDIG(NDIG), .TICK_DIV(TICK_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
        .mode   (mode),
        .target (target),
        .digits (digits),
        .dig_en (dig_en),
        .dig_dir(dig_dir),
        .dig_clr(dig_clr),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // Plant: a bank of BCD counters obeying the controller, plus an illegal-code overlay.
    logic [3:0]  bank [NDIG];
    logic        bad      = 1'b0;
    int unsigned bad_idx  = 0;
    logic [3:0]  bad_code = 4'hC;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NDIG; i++) bank[i] <= 4'd0;
        end else if (dig_clr) begin
            for (int i = 0; i < NDIG; i++) bank[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (dig_en[i]) begin
                    if (dig_dir) bank[i] <= (bank[i] == 4'd9) ? 4'd0 : bank[i] + 4'd1;
                    else         bank[i] <= (bank[i] == 4'd0) ? 4'd9 : bank[i] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        digits = '0;
        for (int i = 0; i < NDIG; i++) begin
            digits[4*i +: 4] = (bad && (bad_idx == i)) ? bad_code : bank[i];
        end
    end

    // Reference model
    typedef enum {MIdle, MRun, MPause, MDone} mph_e;
    typedef struct packed {
        logic [NDIG-1:0] en;
        logic            dir;
        logic            clr;
        logic            busy;
        logic            done;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    mph_e m_ph, n_ph;
    int   m_remain, n_remain;  // RUN cycles until the next tick, counting the current one
    bit   m_up, n_up, m_err, n_err, m_donep, n_donep;

    int tests = 0;
    int fails = 0;
    int en0_cnt = 0;
    int en1_cnt = 0;
    bit saw_done = 0;
    logic [NDIG-1:0] smp_en;
    logic [W-1:0]    smp_dig;
    logic            smp_clr, smp_busy, smp_done, smp_err, smp_dir;

    function automatic bit is_legal(input logic [W-1:0] d);
        for (int i = 0; i < NDIG; i++) if (d[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int unsigned to_int(input logic [W-1:0] d);
        int unsigned v = 0;
        for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(d[4*i +: 4]);
        return v;
    endfunction

    function automatic int unsigned pow10(input int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic model_init();
        m_ph = MIdle; m_remain = TICK_DIV; m_up = 1; m_err = 0; m_donep = 0;
        n_ph = MIdle; n_remain = TICK_DIV; n_up = 1; n_err = 0; n_donep = 0;
    endtask

    task automatic model_eval();
        exp_t        e;
        bit          ill, act, trm, tk;
        int unsigned v, t, p;
        ill = !is_legal(digits);
        v   = to_int(digits);
        t   = to_int(target);
        act = (m_ph == MRun) || (m_ph == MPause);
        trm = m_up ? (v == t) : (v == 0);
        tk  = (m_ph == MRun) && (m_remain == 1);
        e.en = '0;
        if ((m_ph == MRun) && !clear && !ill && !trm && tk) begin
            for (int i = 0; i < NDIG; i++) begin
                p = pow10(i);
                e.en[i] = m_up ? ((v % p) == p - 1) : ((v % p) == 0);
            end
        end
        e.dir  = m_up;
        e.clr  = clear || (ill && act);
        e.busy = act;
        e.done = m_donep;
        e.err  = m_err;
        exp_q.push_back(e);

        n_ph = m_ph; n_remain = m_remain; n_up = m_up; n_err = m_err; n_donep = 0;
        if (m_ph == MRun) n_remain = (m_remain == 1) ? TICK_DIV : m_remain - 1;
        if (clear) begin
            n_ph = MIdle; n_err = 0;
        end else if (ill && act) begin
            n_ph = MIdle; n_err = 1;
        end else begin
            case (m_ph)
                MIdle, MDone: if (start) begin
                    n_ph = MRun; n_up = !mode; n_remain = TICK_DIV;
                end
                MRun: begin
                    if (trm) begin
                        n_ph = MDone; n_donep = 1;
                    end else if (stop) begin
                        n_ph = MPause;
                    end
                end
                MPause: if (stop || start) n_ph = MRun;
                default: n_ph = MIdle;
            endcase
        end
    endtask

    // One clock cycle: entered and left at posedge + 1.
    task automatic step(input logic st, input logic sp, input logic cl, input logic md,
                        input logic bd);
        m_ph = n_ph; m_remain = n_remain; m_up = n_up; m_err = n_err; m_donep = n_donep;
        start = st; stop = sp; clear = cl; mode = md; bad = bd;
        if (bd) begin
            bad_idx  = $urandom_range(0, NDIG - 1);
            bad_code = 4'($urandom_range(10, 15));
        end
        #1;
        model_eval();
        #2;
        smp_en = dig_en; smp_clr = dig_clr; smp_busy = busy; smp_done = done;
        smp_err = err; smp_dir = dig_dir; smp_dig = digits;
        if (dig_en[0]) en0_cnt++;
        if (dig_en[1]) en1_cnt++;
        if (done) saw_done = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic run_until_done(input int maxc, input string name);
        int k = 0;
        while (!saw_done && k < maxc) begin
            idle();
            k++;
        end
        chk(name, int'(saw_done), 1);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_dig_en", int'(dig_en), 0);
        chk("rst_dig_clr", int'(dig_clr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_dig_dir", int'(dig_dir), 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_init();
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        exp_t got;
        if (reset && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {dig_en, dig_dir, dig_clr, busy, done, err};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL scoreboard t=%0t: got en=%b dir=%b clr=%b busy=%b done=%b err=%b, expected en=%b dir=%b clr=%b busy=%b done=%b err=%b",
                         $time, got.en, got.dir, got.clr, got.busy, got.done, got.err,
                         e.en, e.dir, e.clr, e.busy, e.done, e.err);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_init();
        @(posedge clk);
        #1;
        do_reset();

        // Up count 00 -> 12
        target = 8'h12; en1_cnt = 0; saw_done = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until_done(200, "up12_done_seen");
        chk("up12_digits", int'(smp_dig), 'h12);
        chk("up12_en1_pulses", en1_cnt, 1);
        en0_cnt = 0;
        repeat (10) idle();
        chk("up12_no_en_after_done", en0_cnt, 0);

        // Restart from DONE with digits == target: back to DONE straight away
        saw_done = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        chk("redone_pulse", int'(smp_done), 1);

        // Up to 21, then down to 00
        target = 8'h21; saw_done = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until_done(200, "up21_done_seen");
        chk("up21_digits", int'(smp_dig), 'h21);
        en1_cnt = 0; saw_done = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("down_dir", int'(smp_dir), 0);
        run_until_done(300, "down_done_seen");
        chk("down_digits", int'(smp_dig), 0);
        chk("down_en1_pulses", en1_cnt, 2);

        // Pause with prescaler holding 2, resume: tick two cycles after the resume pulse
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        target = 8'h99;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        en0_cnt = 0;
        repeat (10) idle();
        chk("pause_no_en", en0_cnt, 0);
        chk("pause_busy", int'(smp_busy), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("resume_cycle1_en0", int'(smp_en[0]), 0);
        idle();
        chk("resume_cycle2_en0", int'(smp_en[0]), 1);

        // Illegal digit during RUN
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ill_dig_clr", int'(smp_clr), 1);
        chk("ill_dig_en", int'(smp_en), 0);
        idle();
        chk("ill_busy", int'(smp_busy), 0);
        chk("ill_err", int'(smp_err), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("ill_err_cleared", int'(smp_err), 0);

        // clear + stop + start together in PAUSE
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("combo_paused", int'(smp_busy), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("combo_clr", int'(smp_clr), 1);
        idle();
        chk("combo_idle", int'(smp_busy), 0);
        chk("combo_clr_once", int'(smp_clr), 0);

        // Asynchronous reset in the middle of RUN
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        do_reset();

        // Randomised traffic
        repeat (3000) begin
            if ($urandom_range(0, 99) == 0) target = rand_bcd();
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 149) == 0));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
